// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locking arbiter sharing one AXI4-Stream UART transmit channel
// clk, rst (sync, active-high); s_axis_tdata/tvalid/tlast/tready: per-source streams, data packed source-major;
// m_axis_tdata/tvalid/tlast/tid/tready: registered output stream; busy: grant held; trunc_error: MAX_BEATS release pulse
module uart_tx_arb #(
  parameter int PORTS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS = 256,
  localparam int ID_WIDTH = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [ID_WIDTH-1:0]         m_axis_tid,
  output logic                        busy,
  output logic                        trunc_error
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [ID_WIDTH-1:0] grant, rr_ptr, pick, idx;
  logic [15:0] beat_cnt;
  logic out_rdy, accept, at_max, rel;
  assign out_rdy = !m_axis_tvalid || m_axis_tready;
  assign at_max = beat_cnt == 16'(MAX_BEATS - 1);
  assign busy = state == ACTIVE;
  // scan from the highest offset down so the nearest valid source after rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    idx = rr_ptr;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = ID_WIDTH'((int'(rr_ptr) + i) % PORTS);
      pick = s_axis_tvalid[idx] ? idx : pick;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    s_axis_tready = '0;
    accept = 1'b0;
    rel = 1'b0;
    if (state == IDLE) begin
      state_nxt = |s_axis_tvalid ? ACTIVE : IDLE;
    end else begin
      s_axis_tready[grant] = out_rdy;
      accept = s_axis_tvalid[grant] && out_rdy;
      rel = accept && (s_axis_tlast[grant] || at_max);
      state_nxt = rel ? IDLE : ACTIVE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tid <= '0;
      trunc_error <= 1'b0;
    end else begin
      trunc_error <= accept && at_max && !s_axis_tlast[grant];
      if (state == IDLE) begin
        grant <= pick;
        beat_cnt <= '0;
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 16'd1;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast <= s_axis_tlast[grant] || at_max;
        m_axis_tid <= grant;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (rel) rr_ptr <= grant == ID_WIDTH'(PORTS - 1) ? '0 : grant + ID_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb with directed scenarios and randomized traffic
module tb_uart_tx_arb;
  localparam int PORTS = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  typedef struct packed {logic [DW-1:0] d; logic l; logic t;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PORTS*DW-1:0] s_axis_tdata = '0;
  logic [PORTS-1:0] s_axis_tvalid = '0;
  logic [PORTS-1:0] s_axis_tlast = '0;
  logic [PORTS-1:0] s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic m_axis_tlast;
  logic [1:0] m_axis_tid;
  logic busy;
  logic trunc_error;
  uart_tx_arb #(.PORTS(PORTS), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .busy(busy), .trunc_error(trunc_error)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int n_trunc = 0;
  beat_t drv_q[PORTS][$];
  beat_t exp_q[PORTS][$];
  int seg[PORTS];
  int order_q[$];
  bit rdy_q[$];
  int rdy_mode = 0;
  bit gap_en = 0;
  logic [PORTS-1:0] hs_last = '0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bad(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask
  function automatic bit pending();
    for (int i = 0; i < PORTS; i++) if (exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction
  // model: each grant carries at most MB beats, so a source's stream is cut into
  // segments ending at its tlast or at every MB-th beat since the last cut
  task automatic push_pkt(int src, int n, int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = DW'(base + k);
      b.l = k == n - 1;
      b.t = 1'b0;
      drv_q[src].push_back(b);
      b.t = !b.l && seg[src] == MB - 1;
      b.l = b.l || b.t;
      exp_q[src].push_back(b);
      seg[src] = b.l ? 0 : seg[src] + 1;
    end
  endtask
  task automatic tick();
    logic [PORTS-1:0] hs;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk);
    #1;
    hs_last = hs;
    for (int i = 0; i < PORTS; i++) begin
      if (hs[i]) void'(drv_q[i].pop_front());
      if (!(s_axis_tvalid[i] && !hs[i])) begin
        if (drv_q[i].size() != 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
          s_axis_tvalid[i] = 1'b1;
          s_axis_tdata[i*DW +: DW] = drv_q[i][0].d;
          s_axis_tlast[i] = drv_q[i][0].l;
        end else begin
          s_axis_tvalid[i] = 1'b0;
        end
      end
    end
    m_axis_tready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) :
                    (rdy_mode == 2 && rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
      seg[i] = 0;
    end
    order_q.delete();
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tid", m_axis_tid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc_error, 0);
  endtask
  task automatic drain(int bound);
    int k = 0;
    while ((pending() || m_axis_tvalid) && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) bad("drain_timeout");
    repeat (3) tick();
    chk("order_done", order_q.size(), 0);
  endtask
  logic p_v = 0, p_r = 0, p_l = 0, in_pkt = 0;
  logic [DW-1:0] p_d = '0;
  logic [1:0] p_id = '0, cur = '0;
  always @(negedge clk) begin
    beat_t e;
    logic nb, et;
    if (rst) begin
      p_v = 1'b0;
      p_r = 1'b0;
      in_pkt = 1'b0;
    end else begin
      chk("tready_onehot0", 32'($onehot0(s_axis_tready)), 1);
      if (m_axis_tvalid && !m_axis_tready) chk("tready_stall", s_axis_tready, 0);
      if (|s_axis_tready) chk("busy_grant", busy, 1);
      if (p_v && !p_r) chk("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid}, {1'b1, p_d, p_l, p_id});
      nb = m_axis_tvalid && (!p_v || p_r);
      et = nb && exp_q[m_axis_tid].size() != 0 && exp_q[m_axis_tid][0].t;
      chk("trunc_error", trunc_error, et);
      if (trunc_error) n_trunc++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q[m_axis_tid].size() == 0) bad("unexpected_beat");
        else begin
          e = exp_q[m_axis_tid].pop_front();
          chk("beat_data", m_axis_tdata, e.d);
          chk("beat_last", m_axis_tlast, e.l);
        end
        if (in_pkt) chk("no_interleave", m_axis_tid, cur);
        else if (order_q.size() != 0) chk("grant_order", m_axis_tid, order_q.pop_front());
        cur = m_axis_tid;
        in_pkt = !m_axis_tlast;
      end
      p_v = m_axis_tvalid;
      p_r = m_axis_tready;
      p_d = m_axis_tdata;
      p_l = m_axis_tlast;
      p_id = m_axis_tid;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int cnt, k;
    for (int i = 0; i < PORTS; i++) seg[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    push_pkt(2, 3, 8'h41);
    tick();
    tick();
    chk("lat_busy", busy, 1);
    chk("lat_tready", s_axis_tready, 4'b0100);
    tick();
    chk("lat_accept1", hs_last[2], 1);
    chk("lat_mvalid", m_axis_tvalid, 1);
    chk("lat_tid", m_axis_tid, 2);
    chk("lat_tdata", m_axis_tdata, 8'h41);
    chk("lat_tlast1", m_axis_tlast, 0);
    tick();
    chk("consec2", hs_last[2], 1);
    chk("busy_mid", busy, 1);
    tick();
    chk("consec3", hs_last[2], 1);
    chk("busy_fall", busy, 0);
    chk("tlast3", m_axis_tlast, 1);
    drain(100);
    push_pkt(3, 1, 8'h70);
    push_pkt(0, 1, 8'h60);
    order_q = '{3, 0};
    drain(100);
    do_reset();
    push_pkt(0, 2, 8'h10);
    push_pkt(1, 2, 8'h20);
    push_pkt(3, 2, 8'h30);
    push_pkt(0, 2, 8'h18);
    order_q = '{0, 1, 3, 0};
    drain(200);
    rdy_mode = 2;
    rdy_q = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1};
    push_pkt(1, 4, 8'h80);
    order_q = '{1};
    drain(200);
    rdy_mode = 0;
    do_reset();
    n_trunc = 0;
    push_pkt(0, 6, 8'h50);
    push_pkt(2, 2, 8'h90);
    order_q = '{0, 2, 0};
    drain(200);
    chk("trunc_pulses", n_trunc, 1);
    push_pkt(1, 5, 8'hA0);
    cnt = 0;
    k = 0;
    while (cnt < 2 && k < 50) begin
      tick();
      if (hs_last[1]) cnt++;
      k++;
    end
    if (cnt < 2) bad("rst_mid_wait");
    do_reset();
    push_pkt(3, 2, 8'hB0);
    push_pkt(0, 2, 8'hC0);
    order_q = '{0, 3};
    drain(200);
    gap_en = 1;
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      push_pkt($urandom_range(0, PORTS - 1), $urandom_range(1, 7), $urandom_range(0, 255));
      repeat ($urandom_range(0, 6)) tick();
    end
    drain(5000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
